// File: rtl/logic_pipe2.sv
// logic_pipe2: two-level selectable bitwise gate combiner with two register
// stages and valid/ready handshakes on both sides.
//   Level 1: ab = f(op_ab, a, b), cd = f(op_cd, c, d)   -> stage 1 registers
//   Level 2: y  = f(op_y, ab, cd), y_zero = (y == 0)     -> stage 2 registers
// Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(x), 7 BUF(x).
// Optional macro LOGIC_PIPE_TXN_CNT_EN adds a saturating output-handshake
// counter on port txn_count[CNT_W-1:0].
module logic_pipe2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op_ab,
  input  logic [2:0]       op_cd,
  input  logic [2:0]       op_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
`ifdef LOGIC_PIPE_TXN_CNT_EN
  ,
  output logic [CNT_W-1:0] txn_count
`endif
);

  // Reject degenerate widths at elaboration time rather than building nonsense.
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("logic_pipe2: WIDTH and CNT_W must both be >= 1");
  end

  // Opcode evaluation shared by both levels; x is the first operand.
  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = ~(x & z);
      3'd3:    r = ~(x | z);
      3'd4:    r = x ^ z;
      3'd5:    r = ~(x ^ z);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // Stage 1 state
  logic             v1_q;
  logic [WIDTH-1:0] ab_q;
  logic [WIDTH-1:0] cd_q;
  logic [2:0]       opy_q;

  // Stage 2 state
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             y_zero_q;

  // Next-state values for the data registers
  logic [WIDTH-1:0] ab_d;
  logic [WIDTH-1:0] cd_d;
  logic [WIDTH-1:0] y_d;

  logic s2_adv;
  logic in_fire;
  logic out_fire;

  // Stage 2 can take stage 1's word when it is empty or being drained now.
  assign s2_adv   = v1_q && (!out_valid_q || out_ready);
  // Stage 1 can accept when empty or when its word moves on this edge.
  assign in_ready = !v1_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign ab_d = gate_f(op_ab, a, b);
  assign cd_d = gate_f(op_cd, c, d);
  assign y_d  = gate_f(opy_q, ab_q, cd_q);

  // Stage 1: capture level-1 results together with the level-2 opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      ab_q  <= '0;
      cd_q  <= '0;
      opy_q <= 3'd0;
    end else if (in_fire) begin
      v1_q  <= 1'b1;
      ab_q  <= ab_d;
      cd_q  <= cd_d;
      opy_q <= op_y;
    end else if (s2_adv) begin
      v1_q  <= 1'b0;
    end
  end

  // Stage 2: combine stage-1 results; hold steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b1;
    end else if (s2_adv) begin
      out_valid_q <= 1'b1;
      y_q         <= y_d;
      y_zero_q    <= (y_d == '0);
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;

`ifdef LOGIC_PIPE_TXN_CNT_EN
  logic [CNT_W-1:0] txn_count_q;

  // Count output handshakes, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= '0;
    end else if (out_fire && (txn_count_q != {CNT_W{1'b1}})) begin
      txn_count_q <= txn_count_q + 1'b1;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_logic_pipe2.sv
// Self-checking bench for logic_pipe2 (WIDTH=8, CNT_W=4): directed cases plus
// randomized traffic against a queue-based reference model.
module tb_logic_pipe2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic [2:0]   op_ab, op_cd, op_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         y_zero;
`ifdef LOGIC_PIPE_TXN_CNT_EN
  logic [3:0]   txn_count;
`endif

  logic_pipe2 #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .op_ab    (op_ab),
    .op_cd    (op_cd),
    .op_y     (op_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .y_zero   (y_zero)
`ifdef LOGIC_PIPE_TXN_CNT_EN
    ,
    .txn_count(txn_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of expected results tagged with the accept edge.
  typedef struct packed {
    logic [W-1:0] y;
    int unsigned  acc;
  } exp_t;

  exp_t         q[$];
  int unsigned  edges;
  int           n_checks;
  int           n_fail;
  int           cnt_model;
  int           n_txn;
  logic         last_fire_in;
  logic         stall_prev;
  logic [W-1:0] held_y;

  function automatic logic [W-1:0] gate_ref(input logic [2:0] op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] z);
    case (op)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: entered just after a negedge with inputs driven,
  // returns at the following negedge.
  task automatic cycle();
    logic fire_in, fire_out, exp_ov;
    exp_t e;
    #1;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    check_eq("in_ready", in_ready, (q.size() < 2) || out_ready);
    exp_ov = (q.size() > 0) && (edges >= q[0].acc + 2);
    check_eq("out_valid", out_valid, exp_ov);
    if (out_valid && exp_ov) begin
      check_eq("y", y, q[0].y);
      check_eq("y_zero", y_zero, q[0].y == 0);
    end
    if (stall_prev) begin
      check_eq("stall_y", y, held_y);
    end
    if (fire_out && q.size() > 0) begin
      $display("txn %0d y=%02h y_zero=%0b", n_txn, y, y_zero);
      n_txn++;
      void'(q.pop_front());
      if (cnt_model < 15) cnt_model++;
    end
    stall_prev = out_valid && !out_ready;
    held_y     = y;
    if (fire_in) begin
      e.y   = gate_ref(op_y, gate_ref(op_ab, a, b), gate_ref(op_cd, c, d));
      e.acc = edges;
      q.push_back(e);
    end
    last_fire_in = fire_in;
    @(posedge clk);
    edges++;
`ifdef LOGIC_PIPE_TXN_CNT_EN
    #1;
    check_eq("txn_count", {28'd0, txn_count}, cnt_model);
`endif
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ic, input logic [W-1:0] id,
                      input logic [2:0] oab, input logic [2:0] ocd, input logic [2:0] oy);
    a = ia; b = ib; c = ic; d = id;
    op_ab = oab; op_cd = ocd; op_y = oy;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_fire_in) return;
    end
    check_eq("send_timeout", last_fire_in, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    check_eq("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; cnt_model = 0; n_txn = 0; edges = 0;
    stall_prev = 1'b0; held_y = '0; last_fire_in = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0; op_ab = 3'd0; op_cd = 3'd0; op_y = 3'd0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_y_zero", y_zero, 1);
    check_eq("rst_in_ready", in_ready, 1);
`ifdef LOGIC_PIPE_TXN_CNT_EN
    check_eq("rst_txn_count", {28'd0, txn_count}, 0);
`endif
    rst = 1'b0;

    // Mixed opcodes, two-stage latency
    send(8'hF0, 8'hCC, 8'hAA, 8'h0F, 3'd0, 3'd1, 3'd4);
    in_valid = 1'b0;
    #1 check_eq("mix_not_early", out_valid, 0);
    cycle();
    check_eq("mix_valid", out_valid, 1);
    check_eq("mix_y", y, 8'h6F);
    check_eq("mix_y_zero", y_zero, 0);
    drain();

    // Unary ops with random ignored operands
    send(8'hF0, 8'($urandom), 8'h0F, 8'($urandom), 3'd6, 3'd7, 3'd5);
    in_valid = 1'b0;
    cycle();
    check_eq("unary_y", y, 8'hFF);
    check_eq("unary_y_zero", y_zero, 0);
    drain();

    // Zero flag then NOR on the same data, back to back
    send(8'h55, 8'h55, 8'h55, 8'h55, 3'd1, 3'd0, 3'd4);
    send(8'h55, 8'h55, 8'h55, 8'h55, 3'd1, 3'd0, 3'd3);
    check_eq("zero_y", y, 8'h00);
    check_eq("zero_flag", y_zero, 1);
    in_valid = 1'b0;
    cycle();
    check_eq("nor_y", y, 8'hAA);
    check_eq("nor_flag", y_zero, 0);
    drain();

    // Backpressure: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    send(8'hF0, 8'hCC, 8'hAA, 8'h0F, 3'd0, 3'd1, 3'd4);
    send(8'h55, 8'h55, 8'h55, 8'h55, 3'd1, 3'd0, 3'd3);
    a = 8'h12; b = 8'h34; c = 8'h56; d = 8'h78;
    op_ab = 3'd4; op_cd = 3'd2; op_y = 3'd1;
    in_valid = 1'b1;
    #1;
    check_eq("bp_refuse", in_ready, 0);
    check_eq("bp_hold_y", y, 8'h6F);
    #1;
    for (int k = 0; k < 3; k++) cycle();
    check_eq("bp_depth", q.size(), 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !last_fire_in; k++) cycle();
    check_eq("bp_third_in", last_fire_in, 1);
    drain();

    // Asynchronous reset between edges with both stages full
    out_ready = 1'b0;
    send(8'h0F, 8'hFF, 8'h33, 8'h11, 3'd0, 3'd4, 3'd1);
    send(8'hA5, 8'h5A, 8'hC3, 8'h3C, 3'd4, 3'd5, 3'd0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_y", y, 0);
    check_eq("arst_y_zero", y_zero, 1);
    check_eq("arst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    cnt_model = 0;
    @(posedge clk);
    edges++;
`ifdef LOGIC_PIPE_TXN_CNT_EN
    #1 check_eq("arst_txn_count", {28'd0, txn_count}, 0);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    send(8'hF0, 8'hCC, 8'hAA, 8'h0F, 3'd0, 3'd1, 3'd4);
    in_valid = 1'b0;
    cycle();
    check_eq("post_rst_valid", out_valid, 1);
    check_eq("post_rst_y", y, 8'h6F);
    drain();

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      op_ab = 3'($urandom_range(0, 7));
      op_cd = 3'($urandom_range(0, 7));
      op_y  = 3'($urandom_range(0, 7));
      cycle();
    end
    drain();
`ifdef LOGIC_PIPE_TXN_CNT_EN
    check_eq("txn_saturated", {28'd0, txn_count}, 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_pipe2.md
Name: logic_pipe2

Overview:
- Parametrised, pipelined successor to the fixed two-level gate netlist.
- Level 1: two runtime-selectable bitwise gates, on (a,b) and on (c,d). Level 2: a third selectable gate combines the two results.
- WIDTH-bit datapath, two register stages, valid/ready handshake on input and output.
- Used as the standard registered logic-combiner in generated gate examples and datapaths.

Parameters:
- WIDTH, 8, data width of a, b, c, d, y (>=1)
- CNT_W, 16, width of transaction counter; used only when LOGIC_PIPE_TXN_CNT_EN is defined (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  input transaction valid
- in_ready  output  1  block can accept input this cycle
- a, b, c, d  input  WIDTH each  operands
- op_ab  input  3  level-1 opcode applied to (a,b)
- op_cd  input  3  level-1 opcode applied to (c,d)
- op_y  input  3  level-2 opcode applied to (ab result, cd result)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  result
- y_zero  output  1  high when y == 0 (registered alongside y)
- txn_count  output  CNT_W  only when LOGIC_PIPE_TXN_CNT_EN is defined

Behaviour:
- Opcode encoding, first operand = x, second = z:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT: ~x, z ignored
  - 7 BUF: x, z ignored
  - All ops bitwise over WIDTH bits; no carries, no width change.
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Stage 1 registers: v1, ab_r = f(op_ab,a,b), cd_r = f(op_cd,c,d), opy_r = op_y. Opcodes are sampled together with their data.
- Stage 2 registers: out_valid, y = f(opy_r,ab_r,cd_r), y_zero = (f(...) == 0).
- s2_adv = v1 && (!out_valid || out_ready).
- in_ready = !v1 || s2_adv. Combinational from out_ready, v1 and out_valid; no dependency on in_valid.
- Each clock edge:
  - If s2_adv: load stage 2 and set out_valid=1.
  - Else if out_valid && out_ready: clear out_valid.
  - If in_valid && in_ready: load stage 1 and set v1=1.
  - Else if s2_adv: clear v1.
- Latency: an input accepted at edge N presents out_valid with its y after edge N+1, i.e. 2 register stages.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall and ordering:
  - Total capacity is 2 transactions; the third is refused (in_ready=0) until out_ready rises.
  - No data loss, no reordering, no duplication.
  - y, y_zero and out_valid stay stable while out_valid=1 and out_ready=0.
- Simultaneous events: output drain and new input on the same edge with v1=1 → stage 1 moves to stage 2 and the new input enters stage 1 on that edge.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - v1=0, out_valid=0, y=0, y_zero=1, ab_r=0, cd_r=0, opy_r=0, txn_count=0.
  - In-flight transactions are discarded.
  - in_ready=1 while rst is high (v1=0).
- Data registers may update freely while their valid bit is low. After reset they hold the reset values until first loaded.

Optional Feature:
- Macro: LOGIC_PIPE_TXN_CNT_EN.
- Defined:
  - Port txn_count[CNT_W-1:0] exists.
  - Increments by 1 on each output handshake (out_valid && out_ready); saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Undefined: port and counter logic are absent. Datapath and handshake behaviour are identical to the defined case.

Test Plan:
- Mixed opcodes, WIDTH=8, out_ready=1:
  - a=F0 b=CC c=AA d=0F, op_ab=AND op_cd=OR op_y=XOR.
  - Expect y=6F, y_zero=0, out_valid exactly 2 cycles after accept.
- Unary ops: a=F0, op_ab=NOT; c=0F, op_cd=BUF; op_y=XNOR; b, d random → y=FF, y_zero=0.
- Zero flag:
  - a=b=c=d=55, op_ab=OR op_cd=AND op_y=XOR → y=00, y_zero=1.
  - Next: op_y=NOR with same data → y=AA, y_zero=0.
- Backpressure:
  - out_ready=0, drive 3 back-to-back valid inputs → first 2 accepted, in_ready=0 on the 3rd; y holds the first result.
  - Raise out_ready → all 3 results emerge in order, one per cycle, no duplicates.
- Reset mid-operation: with v1=1 and out_valid=1, pulse rst between clock edges → out_valid=0, y=0, y_zero=1 immediately. After release, the next input produces a correct result with 2-cycle latency.
- Counter (LOGIC_PIPE_TXN_CNT_EN, CNT_W=4): 20 output handshakes → txn_count=15 (saturated). rst → 0. Build without the macro compiles and passes the tests above.
